// File: rtl/sample_stim_checker.sv
// Stimulus generator and response checker for the a/b sample netlist interface.
// Optional first-mismatch capture is built when SAMPLE_CHK_FIRST_ERR_EN is defined.
module sample_stim_checker #(
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(16'hACE1),
    parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(16'hB400),
    parameter int                NUM_VEC = 256,
    parameter int                LATENCY = 1,
    parameter int                ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             a_o,
    output logic             b_o,
    input  logic             a_inv1_i,
    input  logic             a_inv2_i,
    input  logic             b_inv1_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o
`ifdef SAMPLE_CHK_FIRST_ERR_EN
    ,
    output logic [15:0]      first_err_idx_o,
    output logic [2:0]       first_err_obs_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [15:0]        vec_cnt_q;
    logic [2:0]         drain_cnt_q;
    logic               a_q;
    logic               b_q;
    logic               vld_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic [ERR_W-1:0]   err_cnt_d;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [2:0]         exp_q [LATENCY];

    logic [2:0]         exp_out;
    logic [2:0]         obs;
    logic               exp_vld;
    logic               mismatch;
    logic               start_go;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & TAPS)};
    endfunction

    // Pipe entries are {a, b, valid}; the last stage lines up with the DUT response.
    assign exp_out  = exp_q[LATENCY-1];
    assign exp_vld  = exp_out[0];
    assign obs      = {a_inv1_i, a_inv2_i, b_inv1_i};
    assign mismatch = exp_vld && (obs != {exp_out[2], ~exp_out[2], ~exp_out[1]});
    assign start_go = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_exp_pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    exp_q[gi] <= 3'b000;
                end else if (gi == 0) begin
                    exp_q[gi] <= {a_q, b_q, vld_q};
                end else begin
                    exp_q[gi] <= exp_q[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    // The start edge already presents vector 0, so a run stays busy NUM_VEC+LATENCY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            vec_cnt_q   <= 16'd0;
            drain_cnt_q <= 3'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            vld_q       <= 1'b0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_go) begin
                        state_q     <= (NUM_VEC == 1) ? S_DRAIN : S_RUN;
                        lfsr_q      <= lfsr_step(SEED);
                        vec_cnt_q   <= 16'd1;
                        drain_cnt_q <= 3'd0;
                        a_q         <= SEED[0];
                        b_q         <= SEED[1];
                        vld_q       <= 1'b1;
                        err_cnt_q   <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_q       <= lfsr_q[0];
                    b_q       <= lfsr_q[1];
                    vld_q     <= 1'b1;
                    lfsr_q    <= lfsr_step(lfsr_q);
                    vec_cnt_q <= vec_cnt_q + 16'd1;
                    if (vec_cnt_q == 16'(NUM_VEC - 1)) begin
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= 3'd0;
                    end
                end
                S_DRAIN: begin
                    a_q   <= 1'b0;
                    b_q   <= 1'b0;
                    vld_q <= 1'b0;
                    if (drain_cnt_q == 3'(LATENCY)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_cnt_q;

`ifdef SAMPLE_CHK_FIRST_ERR_EN
    logic [15:0] cmp_cnt_q;
    logic [15:0] first_idx_q;
    logic [2:0]  first_obs_q;
    logic        first_seen_q;

    // cmp_cnt_q equals the index of the vector being compared this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_cnt_q    <= 16'd0;
            first_idx_q  <= 16'd0;
            first_obs_q  <= 3'd0;
            first_seen_q <= 1'b0;
        end else if (start_go) begin
            cmp_cnt_q    <= 16'd0;
            first_idx_q  <= 16'd0;
            first_obs_q  <= 3'd0;
            first_seen_q <= 1'b0;
        end else if (exp_vld) begin
            cmp_cnt_q <= cmp_cnt_q + 16'd1;
            if (mismatch && !first_seen_q) begin
                first_idx_q  <= cmp_cnt_q;
                first_obs_q  <= obs;
                first_seen_q <= 1'b1;
            end
        end
    end

    assign first_err_idx_o = first_idx_q;
    assign first_err_obs_o = first_obs_q;
`else
    // Without first-error capture only err_cnt_o/pass_o report the result.
`endif

endmodule

// File: tb/tb_sample_stim_checker.sv
// Scoreboard bench for sample_stim_checker: a behavioural DUT stand-in with selectable
// faults, a vector-level reference model, and a monitor that checks each finished run.
module tb_sample_stim_checker;

    localparam int N   = 300;
    localparam int L   = 2;
    localparam int EW  = 8;
    localparam int SAT = (1 << EW) - 1;

    localparam int M_IDEAL = 0;
    localparam int M_STUCK = 1;
    localparam int M_BINV  = 2;
    localparam int M_TABLE = 3;
    localparam int M_LAT1  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          a_o, b_o, a_inv1, a_inv2, b_inv1;
    logic          busy_o, done_o, pass_o;
    logic [EW-1:0] err_cnt_o;
`ifdef SAMPLE_CHK_FIRST_ERR_EN
    logic [15:0]   first_err_idx;
    logic [2:0]    first_err_obs;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sample_stim_checker #(
        .LFSR_W (16),
        .SEED   (16'hACE1),
        .NUM_VEC(N),
        .LATENCY(L),
        .ERR_W  (EW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .a_o      (a_o),
        .b_o      (b_o),
        .a_inv1_i (a_inv1),
        .a_inv2_i (a_inv2),
        .b_inv1_i (b_inv1),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .pass_o   (pass_o),
        .err_cnt_o(err_cnt_o)
`ifdef SAMPLE_CHK_FIRST_ERR_EN
        ,
        .first_err_idx_o(first_err_idx),
        .first_err_obs_o(first_err_obs)
`endif
    );

    // Netlist stand-in: L-stage register with optional faults.
    int         mode = M_IDEAL;
    logic [2:0] tbl_mask [4];
    logic [1:0] m_s1 = 2'b00;
    logic [1:0] m_s2 = 2'b00;
    logic [1:0] src;
    logic [2:0] resp;

    always @(posedge clk) begin
        m_s1 <= {a_o, b_o};
        m_s2 <= m_s1;
    end

    always_comb begin
        src  = (mode == M_LAT1) ? m_s1 : m_s2;
        resp = {src[1], ~src[1], ~src[0]} ^ tbl_mask[src];
        if (mode == M_STUCK) resp[1] = 1'b0;
        if (mode == M_BINV)  resp[0] = src[0];
    end

    assign {a_inv1, a_inv2, b_inv1} = resp;

    // Reference vector sequence straight from the LFSR recurrence.
    bit va [N];
    bit vb [N];

    initial begin
        int l;
        l = 16'hACE1;
        for (int k = 0; k < N; k++) begin
            va[k] = l[0];
            vb[k] = l[1];
            l = ((l << 1) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1)) & 16'hFFFF;
        end
    end

    typedef struct {
        int         errs;
        bit         pass;
        int         busy;
        int         fidx;
        logic [2:0] fobs;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t model(input int md);
        exp_t       e;
        int         cnt;
        bit         seen;
        logic [2:0] ideal;
        logic [2:0] got;
        bit         na, nb;
        cnt    = 0;
        seen   = 0;
        e.fidx = 0;
        e.fobs = 3'b000;
        for (int k = 0; k < N; k++) begin
            ideal = {va[k], ~va[k], ~vb[k]};
            na = (k + 1 < N) ? va[k+1] : 1'b0;
            nb = (k + 1 < N) ? vb[k+1] : 1'b0;
            case (md)
                M_STUCK: got = ideal & 3'b101;
                M_BINV:  got = ideal ^ 3'b001;
                M_TABLE: got = ideal ^ tbl_mask[{va[k], vb[k]}];
                M_LAT1:  got = {na, ~na, ~nb};
                default: got = ideal;
            endcase
            if (got != ideal) begin
                cnt++;
                if (!seen) begin
                    seen   = 1;
                    e.fidx = k;
                    e.fobs = got;
                end
            end
        end
        e.errs = (cnt > SAT) ? SAT : cnt;
        e.pass = (cnt == 0);
        e.busy = N + L;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: one scoreboard pop per done rising edge.
    initial begin
        int   busy_cnt = 0;
        bit   busy_prev = 0;
        bit   done_prev = 0;
        int   run_idx = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                busy_prev = 0;
                done_prev = 0;
            end else begin
                if (busy_o && !busy_prev) chk("err_clear_at_start", int'(err_cnt_o), 0);
                if (busy_o) busy_cnt++;
                if (done_o && !done_prev) begin
                    run_idx++;
                    $display("run %0d: err_cnt=%0d pass=%0d busy_cycles=%0d",
                             run_idx, err_cnt_o, pass_o, busy_cnt);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("err_cnt", int'(err_cnt_o), e.errs);
                        chk("pass", int'(pass_o), int'(e.pass));
                        chk("busy_cycles", busy_cnt, e.busy);
                        chk("ab_idle_at_done", int'({a_o, b_o}), 0);
`ifdef SAMPLE_CHK_FIRST_ERR_EN
                        chk("first_err_idx", int'(first_err_idx), e.fidx);
                        chk("first_err_obs", int'(first_err_obs), int'(e.fobs));
`endif
                    end
                    busy_cnt = 0;
                end
                busy_prev = busy_o;
                done_prev = done_o;
            end
        end
    end

    task automatic wait_done(input int n, input bit prev_init);
        int seen = 0;
        bit prev = prev_init;
        int cyc = 0;
        int budget = n * (N + L + 20) + 50;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done_o && !prev) seen++;
            prev = done_o;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: saw %0d done pulses, required %0d", seen, n);
        end
    endtask

    task automatic set_mode(input int md);
        mode = md;
        for (int i = 0; i < 4; i++) tbl_mask[i] = 3'b000;
        if (md == M_TABLE) begin
            for (int i = 0; i < 4; i++) tbl_mask[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // extra_at > 0 pulses start again that many cycles into the run (must be ignored).
    task automatic run_one(input int md, input int extra_at);
        set_mode(md);
        sb_q.push_back(model(md));
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        if (extra_at > 0) begin
            repeat (extra_at) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk) start_i = 1'b0;
        end
        wait_done(1, 1'b0);
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_pass"}, int'(pass_o), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt_o), 0);
        chk({tag, "_a"}, int'(a_o), 0);
        chk({tag, "_b"}, int'(b_o), 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tbl_mask[i] = 3'b000;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_one(M_IDEAL, 0);
        run_one(M_STUCK, 0);
        run_one(M_BINV, N + L - 1);       // start lands in the DRAIN->DONE cycle
        run_one(M_LAT1, 0);
        for (int r = 0; r < 3; r++) run_one(M_TABLE, int'($urandom_range(5, N)));

        // Start held high: exactly one run per DONE entry, back to back.
        set_mode(M_STUCK);
        sb_q.push_back(model(M_STUCK));
        sb_q.push_back(model(M_STUCK));
        @(negedge clk) start_i = 1'b1;
        wait_done(2, done_o);
        start_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a failing run, then a clean rerun.
        set_mode(M_BINV);
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        repeat (100) @(negedge clk);
        chk("prerst_err_nonzero", int'(err_cnt_o != 0), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("midrun_reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_one(M_IDEAL, 0);
        run_one(M_TABLE, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
